// File: rtl/timer_ctrl.sv
// Run-control sequencer for the countdown timer: debounced start/clear buttons,
// the IDLE/LOAD/RUNNING/PAUSED/EXPIRED FSM and the millisecond decrement prescaler.

module timer_ctrl_debounce #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int unsigned    CW       = (CYCLES < 2) ? 1 : $clog2(CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Synchronize the raw button, qualify stability and flag an accepted rising level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync2_r;
          cnt_r   <= {CW{1'b0}};
          press_r <= sync2_r;
        end else begin
          cnt_r   <= cnt_r + CW'(1'b1);
          press_r <= 1'b0;
        end
      end else begin
        cnt_r   <= {CW{1'b0}};
        press_r <= 1'b0;
      end
    end
  end

  assign press = press_r;

endmodule

module timer_ctrl #(
  parameter int unsigned TICK_DIV        = 100000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start_raw,
  input  logic        btn_clear_raw,
  input  logic [26:0] time_in,
  output logic        toggle,
  output logic        timer_reset,
  output logic        running,
  output logic        alarm,
  output logic [2:0]  state
);
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_RUNNING = 3'd2;
  localparam logic [2:0] ST_PAUSED  = 3'd3;
  localparam logic [2:0] ST_EXPIRED = 3'd4;

  localparam int unsigned   PW         = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic          start_s;
  logic          clear_s;
  logic [2:0]    state_r;
  logic [2:0]    next_state_s;
  logic [2:0]    load_dest_r;
  logic [2:0]    next_dest_s;
  logic [PW-1:0] presc_r;
  logic          armed_r;
  logic          stay_running_s;
  logic          tick_s;
  logic          toggle_r;
  logic          timer_reset_r;
  logic          running_r;
  logic          alarm_r;

  timer_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_start_raw),
    .press (start_s)
  );

  timer_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_clear_raw),
    .press (clear_s)
  );

  // Next state and reload destination; clear outranks start, both outrank expiry.
  always_comb begin
    next_state_s = state_r;
    next_dest_s  = load_dest_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_s) begin
          next_state_s = ST_LOAD;
          next_dest_s  = ST_IDLE;
        end else if (start_s) begin
          next_state_s = ST_LOAD;
          next_dest_s  = ST_RUNNING;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        next_state_s = load_dest_r;
      end
      ST_RUNNING: begin
        if (clear_s) begin
          next_state_s = ST_LOAD;
          next_dest_s  = ST_IDLE;
        end else if (start_s) begin
          next_state_s = ST_PAUSED;
        end else if (armed_r && (time_in == 27'd0)) begin
          next_state_s = ST_EXPIRED;
        end else begin
          next_state_s = ST_RUNNING;
        end
      end
      ST_PAUSED: begin
        if (clear_s) begin
          next_state_s = ST_LOAD;
          next_dest_s  = ST_IDLE;
        end else if (start_s) begin
          next_state_s = ST_RUNNING;
        end else begin
          next_state_s = ST_PAUSED;
        end
      end
      ST_EXPIRED: begin
        if (clear_s) begin
          next_state_s = ST_LOAD;
          next_dest_s  = ST_IDLE;
        end else begin
          next_state_s = ST_EXPIRED;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_dest_s  = ST_IDLE;
      end
    endcase
  end

  // The prescaler only advances while RUNNING persists, so any entry restarts a full period.
  assign stay_running_s = (state_r == ST_RUNNING) && (next_state_s == ST_RUNNING);
  assign tick_s         = stay_running_s && (presc_r == PRESC_LAST);

  // FSM state, prescaler, expiry arming and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      load_dest_r   <= ST_IDLE;
      presc_r       <= {PW{1'b0}};
      armed_r       <= 1'b0;
      toggle_r      <= 1'b0;
      timer_reset_r <= 1'b0;
      running_r     <= 1'b0;
      alarm_r       <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      load_dest_r <= next_dest_s;
      if (!stay_running_s || tick_s) begin
        presc_r <= {PW{1'b0}};
      end else begin
        presc_r <= presc_r + PW'(1'b1);
      end
      // Expiry stays disarmed until the reloaded datapath has decremented once.
      if (state_r == ST_LOAD) begin
        armed_r <= 1'b0;
      end else if (tick_s) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
      toggle_r      <= tick_s;
      timer_reset_r <= (next_state_s == ST_LOAD);
      running_r     <= (next_state_s == ST_RUNNING);
      alarm_r       <= (next_state_s == ST_EXPIRED);
    end
  end

  assign toggle      = toggle_r;
  assign timer_reset = timer_reset_r;
  assign running     = running_r;
  assign alarm       = alarm_r;
  assign state       = state_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios then random buttons/time words, every cycle
// compared against a behavioural model of the debounce/FSM/prescaler rules.

module tb_timer_ctrl;
  localparam int TD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_start_raw;
  logic        btn_clear_raw;
  logic [26:0] time_in;
  logic        toggle;
  logic        timer_reset;
  logic        running;
  logic        alarm;
  logic [2:0]  state;

  int vectors     = 0;
  int miscompares = 0;
  int loads       = 0;
  int hold_s      = 0;
  int hold_c      = 0;

  // Model: 0 IDLE, 1 LOAD, 2 RUNNING, 3 PAUSED, 4 EXPIRED
  int m_state = 0;
  int m_dest  = 0;
  int m_age   = 0;
  bit m_armed = 1'b0;
  bit m_tick  = 1'b0;
  bit m_pipe  [2][2];
  bit m_hist  [2][DB];
  bit m_lvl   [2];
  bit m_press [2];
  int m_seen  [2];

  timer_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_start_raw (btn_start_raw),
    .btn_clear_raw (btn_clear_raw),
    .time_in       (time_in),
    .toggle        (toggle),
    .timer_reset   (timer_reset),
    .running       (running),
    .alarm         (alarm),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // A level is accepted once the last DB synchronized samples all disagree with it.
  task automatic deb_edge(input int b, input bit raw);
    bit s;
    bit all_diff;
    s = m_pipe[b][0];
    m_pipe[b][0] = m_pipe[b][1];
    m_pipe[b][1] = raw;
    for (int i = DB - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
    m_hist[b][0] = s;
    m_seen[b]++;
    m_press[b] = 1'b0;
    all_diff = 1'b1;
    for (int j = 0; j < DB; j++) if (m_hist[b][j] == m_lvl[b]) all_diff = 1'b0;
    if (m_seen[b] >= DB && all_diff) begin
      m_lvl[b]   = s;
      m_press[b] = s;
      m_seen[b]  = 0;
    end
  endtask

  task automatic model_edge();
    int nxt;
    bit tick;
    bit ps;
    bit pc;
    if (!reset) begin
      m_state = 0; m_dest = 0; m_age = 0; m_armed = 1'b0; m_tick = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_pipe[b][0] = 1'b0; m_pipe[b][1] = 1'b0;
        m_lvl[b] = 1'b0; m_press[b] = 1'b0; m_seen[b] = 0;
      end
    end else begin
      ps = m_press[0];
      pc = m_press[1];
      nxt = m_state;
      tick = 1'b0;
      case (m_state)
        0: if (pc) begin nxt = 1; m_dest = 0; end else if (ps) begin nxt = 1; m_dest = 2; end
        1: nxt = m_dest;
        2: if (pc) begin nxt = 1; m_dest = 0; end else if (ps) nxt = 3;
           else if (m_armed && time_in == 27'd0) nxt = 4;
        3: if (pc) begin nxt = 1; m_dest = 0; end else if (ps) nxt = 2;
        4: if (pc) begin nxt = 1; m_dest = 0; end
        default: nxt = 0;
      endcase
      // Cycles spent continuously in RUNNING; every TD-th one is a tick.
      if (m_state == 2 && nxt == 2) begin
        m_age++;
        tick = ((m_age % TD) == 0);
      end else begin
        m_age = 0;
      end
      if (m_state == 1) m_armed = 1'b0;
      else if (tick) m_armed = 1'b1;
      m_tick  = tick;
      m_state = nxt;
      deb_edge(0, btn_start_raw);
      deb_edge(1, btn_clear_raw);
    end
  endtask

  task automatic cyc();
    logic [6:0] obs;
    logic [6:0] exp;
    @(posedge clk);
    model_edge();
    #1;
    obs = {state, toggle, timer_reset, running, alarm};
    exp = {3'(m_state), m_tick, (m_state == 1), (m_state == 2), (m_state == 4)};
    check("cycle", 32'(obs), 32'(exp));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    int n = 0;
    while (state !== target && n < budget) begin
      cyc();
      n++;
    end
    check(tag, 32'(state), 32'(target));
  endtask

  task automatic toggle_period(input string tag);
    for (int i = 1; i <= TD; i++) begin
      cyc();
      check(tag, 32'(toggle), (i == TD) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic pulse_start();
    btn_start_raw = 1'b1;
    run(DB + 1);
    btn_start_raw = 1'b0;
  endtask

  task automatic pulse_clear();
    btn_clear_raw = 1'b1;
    run(DB + 1);
    btn_clear_raw = 1'b0;
  endtask

  task automatic go_running(input string tag);
    pulse_start();
    wait_state(tag, 3'd2, 20);
  endtask

  initial begin
    // Reset with start held: no event until it debounces after release.
    reset = 1'b0; btn_start_raw = 1'b1; btn_clear_raw = 1'b0; time_in = 27'h5A5A5A5;
    run(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'({toggle, timer_reset, running, alarm}), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin cyc(); check("t1_hold_idle", 32'(state), 32'd0); end
    cyc(); check("t1_load", 32'(state), 32'd1);
    cyc(); check("t1_run", 32'(state), 32'd2);
    toggle_period("t1_tog");
    btn_start_raw = 1'b0;
    run(DB + 4);
    pulse_clear();
    wait_state("t1_clr_load", 3'd1, 20);
    cyc(); check("t1_clr_idle", 32'(state), 32'd0);
    run(DB + 4);

    // Clean start edge from IDLE.
    btn_start_raw = 1'b1;
    for (int i = 0; i < 5; i++) begin cyc(); check("t2_idle", 32'(state), 32'd0); end
    cyc(); check("t2_load", 32'(state), 32'd1); check("t2_reload", 32'(timer_reset), 32'd1);
    cyc(); check("t2_run", 32'(state), 32'd2); check("t2_running", 32'(running), 32'd1);
    check("t2_reload_off", 32'(timer_reset), 32'd0);
    toggle_period("t2_tog_a");
    toggle_period("t2_tog_b");
    btn_start_raw = 1'b0;
    run(DB + 4);
    pulse_clear();
    wait_state("t2_clr_load", 3'd1, 20);
    cyc(); check("t2_clr_idle", 32'(state), 32'd0);
    run(DB + 4);

    // Bouncing start: exactly one LOAD.
    btn_start_raw = 1'b1; cyc(); btn_start_raw = 1'b0; cyc();
    btn_start_raw = 1'b1; cyc(); btn_start_raw = 1'b0; cyc();
    btn_start_raw = 1'b1;
    loads = 0;
    for (int i = 0; i < 16; i++) begin cyc(); if (state == 3'd1) loads++; end
    check("t3_load_count", 32'(loads), 32'd1);
    check("t3_state", 32'(state), 32'd2);
    btn_start_raw = 1'b0;
    run(DB + 4);
    pulse_clear();
    wait_state("t3_clr_load", 3'd1, 20);
    cyc(); check("t3_clr_idle", 32'(state), 32'd0);
    run(DB + 4);

    // Pause mid-period, then resume with a full fresh period.
    go_running("tp_run");
    pulse_start();
    wait_state("tp_pause", 3'd3, 20);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("tp_paused", 32'({state, toggle}), 32'({3'd3, 1'b0}));
    end
    pulse_start();
    wait_state("tp_resume", 3'd2, 20);
    toggle_period("tp_tog");

    // Expiry: ignored before the first toggle, taken right after it.
    pulse_clear();
    wait_state("t4_clr_load", 3'd1, 20);
    cyc(); check("t4_clr_idle", 32'(state), 32'd0);
    time_in = 27'd0;
    go_running("t4_run");
    for (int i = 0; i < TD - 1; i++) begin
      cyc(); check("t4_unarmed", 32'({state, toggle}), 32'({3'd2, 1'b0}));
    end
    cyc(); check("t4_first_tog", 32'({state, toggle}), 32'({3'd2, 1'b1}));
    cyc(); check("t4_expired", 32'({state, toggle, running, alarm}), 32'({3'd4, 1'b0, 1'b0, 1'b1}));
    pulse_start();
    for (int i = 0; i < 8; i++) begin cyc(); check("t4_start_ignored", 32'(state), 32'd4); end
    pulse_clear();
    wait_state("t4_clr_load", 3'd1, 20);
    check("t4_reload", 32'({timer_reset, alarm}), 32'({1'b1, 1'b0}));
    cyc(); check("t4_idle", 32'({state, alarm}), 32'({3'd0, 1'b0}));
    time_in = 27'h1234567;
    run(DB + 4);

    // Start and clear together while PAUSED: clear wins.
    go_running("t5_run");
    run(DB + 2);
    pulse_start();
    wait_state("t5_pause", 3'd3, 20);
    run(DB + 2);
    btn_start_raw = 1'b1; btn_clear_raw = 1'b1;
    run(DB + 1);
    btn_start_raw = 1'b0; btn_clear_raw = 1'b0;
    wait_state("t5_load", 3'd1, 20);
    cyc(); check("t5_idle", 32'(state), 32'd0);
    run(DB + 4);

    // Reset mid-RUNNING.
    go_running("t6_run");
    run(5);
    reset = 1'b0;
    cyc();
    check("t6_rst", 32'({state, toggle, timer_reset, running, alarm}), 32'd0);
    reset = 1'b1;
    run(DB + 4);

    // Random buttons, time words and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if (hold_s == 0) begin
        btn_start_raw = 1'($urandom_range(0, 1));
        hold_s = $urandom_range(1, 10);
      end
      if (hold_c == 0) begin
        btn_clear_raw = ($urandom_range(0, 3) == 0);
        hold_c = $urandom_range(1, 12);
      end
      hold_s--;
      hold_c--;
      time_in = ($urandom_range(0, 7) == 0) ? 27'd0 : 27'($urandom);
      reset = ($urandom_range(0, 299) != 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
